// File: rtl/gshare_branch_predictor.sv
// Fetch-stage branch predictor: direct-mapped BTB, gshare PHT and circular RAS.
// Predicts combinationally from pc; speculates on fetch, trains and recovers from ID updates.
module gshare_branch_predictor #(
  parameter int unsigned BTB_INDEX_BITS = 6,
  parameter int unsigned BHT_INDEX_BITS = 8,
  parameter int unsigned GHR_BITS       = 8,
  parameter int unsigned RAS_PTR_BITS   = 3
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    fetch_valid,
  input  logic [31:0]             pc,
  output logic [31:0]             pred_next_pc,
  output logic                    pred_br_taken,
  output logic [GHR_BITS-1:0]     pred_ghr,
  output logic [RAS_PTR_BITS-1:0] pred_ras_ptr,
  input  logic                    upd_en,
  input  logic [31:0]             upd_inst_addr,
  input  logic                    upd_br_inst,
  input  logic [1:0]              upd_br_type,
  input  logic                    upd_br_taken,
  input  logic [31:0]             upd_br_target,
  input  logic                    upd_mispredict,
  input  logic [GHR_BITS-1:0]     upd_ghr,
  input  logic [RAS_PTR_BITS-1:0] upd_ras_ptr
);

  localparam int unsigned BtbN = 1 << BTB_INDEX_BITS;
  localparam int unsigned PhtN = 1 << BHT_INDEX_BITS;
  localparam int unsigned RasN = 1 << RAS_PTR_BITS;
  localparam int unsigned TagW = 30 - BTB_INDEX_BITS;

  localparam logic [1:0] TypeCond = 2'b00;
  localparam logic [1:0] TypeCall = 2'b10;
  localparam logic [1:0] TypeRet  = 2'b11;

  logic [BtbN-1:0]         r_btb_valid;
  logic [TagW-1:0]         r_btb_tag    [BtbN];
  logic [31:0]             r_btb_target [BtbN];
  logic [1:0]              r_btb_type   [BtbN];
  logic [1:0]              r_pht        [PhtN];
  logic [31:0]             r_ras        [RasN];
  logic [GHR_BITS-1:0]     r_ghr;
  logic [RAS_PTR_BITS-1:0] r_tos;

  logic [BTB_INDEX_BITS-1:0] w_btb_idx;
  logic [BHT_INDEX_BITS-1:0] w_pht_idx;
  logic                      w_hit;
  logic                      w_taken;
  logic [1:0]                w_type;
  logic [31:0]               w_pc_plus4;

  logic [BTB_INDEX_BITS-1:0] w_upd_btb_idx;
  logic [BHT_INDEX_BITS-1:0] w_upd_pht_idx;
  logic                      w_train;
  logic                      w_recover;
  logic                      w_spec;

  logic [GHR_BITS-1:0]       w_ghr_d;
  logic [RAS_PTR_BITS-1:0]   w_tos_d;
  logic                      w_ras_we;
  logic [RAS_PTR_BITS-1:0]   w_ras_widx;
  logic [31:0]               w_ras_wdata;

  // Lookup
  assign w_btb_idx  = pc[BTB_INDEX_BITS+1:2];
  assign w_pht_idx  = pc[BHT_INDEX_BITS+1:2] ^ BHT_INDEX_BITS'(r_ghr);
  assign w_hit      = r_btb_valid[w_btb_idx] && (r_btb_tag[w_btb_idx] == pc[31:BTB_INDEX_BITS+2]);
  assign w_type     = r_btb_type[w_btb_idx];
  assign w_taken    = w_hit && ((w_type == TypeCond) ? r_pht[w_pht_idx][1] : 1'b1);
  assign w_pc_plus4 = pc + 32'd4;

  always_comb begin
    pred_next_pc = w_pc_plus4;
    if (w_taken) begin
      pred_next_pc = (w_type == TypeRet) ? r_ras[r_tos] : r_btb_target[w_btb_idx];
    end
  end

  assign pred_br_taken = w_taken;
  assign pred_ghr      = r_ghr;
  assign pred_ras_ptr  = r_tos;

  assign w_upd_btb_idx = upd_inst_addr[BTB_INDEX_BITS+1:2];
  assign w_upd_pht_idx = upd_inst_addr[BHT_INDEX_BITS+1:2] ^ BHT_INDEX_BITS'(upd_ghr);
  assign w_train       = upd_en && upd_br_inst;
  assign w_recover     = upd_en && upd_mispredict;
  // The fetched instruction is flushed on recovery, so its speculation is dropped.
  assign w_spec        = fetch_valid && w_hit && !w_recover;

  always_comb begin
    w_ghr_d     = r_ghr;
    w_tos_d     = r_tos;
    w_ras_we    = 1'b0;
    w_ras_widx  = r_tos + 1'b1;
    w_ras_wdata = w_pc_plus4;
    if (w_recover) begin
      if (upd_br_inst && (upd_br_type == TypeCond)) begin
        w_ghr_d = {upd_ghr[GHR_BITS-2:0], upd_br_taken};
      end else begin
        w_ghr_d = upd_ghr;
      end
      unique case (upd_br_type)
        TypeCall: begin
          w_tos_d     = upd_ras_ptr + 1'b1;
          w_ras_we    = 1'b1;
          w_ras_widx  = upd_ras_ptr + 1'b1;
          w_ras_wdata = upd_inst_addr + 32'd4;
        end
        TypeRet: w_tos_d = upd_ras_ptr - 1'b1;
        default: w_tos_d = upd_ras_ptr;
      endcase
    end else if (w_spec) begin
      unique case (w_type)
        TypeCond: w_ghr_d = {r_ghr[GHR_BITS-2:0], w_taken};
        TypeCall: begin
          w_tos_d  = r_tos + 1'b1;
          w_ras_we = 1'b1;
        end
        TypeRet:  w_tos_d = r_tos - 1'b1;
        default:  ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_ghr <= '0;
      r_tos <= '0;
      for (int i = 0; i < int'(RasN); i++) r_ras[i] <= '0;
    end else begin
      r_ghr <= w_ghr_d;
      r_tos <= w_tos_d;
      if (w_ras_we) r_ras[w_ras_widx] <= w_ras_wdata;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_btb_valid <= '0;
    end else if (w_train) begin
      r_btb_valid[w_upd_btb_idx] <= 1'b1;
    end
  end

  // Tag, target and type are qualified by valid, so they need no reset.
  always_ff @(posedge clk) begin
    if (w_train) begin
      r_btb_tag[w_upd_btb_idx]    <= upd_inst_addr[31:BTB_INDEX_BITS+2];
      r_btb_target[w_upd_btb_idx] <= upd_br_target;
      r_btb_type[w_upd_btb_idx]   <= upd_br_type;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < int'(PhtN); i++) r_pht[i] <= 2'b01;
    end else if (w_train && (upd_br_type == TypeCond)) begin
      if (upd_br_taken) begin
        if (r_pht[w_upd_pht_idx] != 2'b11) r_pht[w_upd_pht_idx] <= r_pht[w_upd_pht_idx] + 2'b01;
      end else begin
        if (r_pht[w_upd_pht_idx] != 2'b00) r_pht[w_upd_pht_idx] <= r_pht[w_upd_pht_idx] - 2'b01;
      end
    end
  end

endmodule

// File: tb/tb_gshare_branch_predictor.sv
// Directed self-checking bench for gshare_branch_predictor (default parameters).
module tb_gshare_branch_predictor;

  logic        clk = 1'b0;
  logic        resetn;
  logic        fetch_valid;
  logic [31:0] pc;
  logic [31:0] pred_next_pc;
  logic        pred_br_taken;
  logic [7:0]  pred_ghr;
  logic [2:0]  pred_ras_ptr;
  logic        upd_en;
  logic [31:0] upd_inst_addr;
  logic        upd_br_inst;
  logic [1:0]  upd_br_type;
  logic        upd_br_taken;
  logic [31:0] upd_br_target;
  logic        upd_mispredict;
  logic [7:0]  upd_ghr;
  logic [2:0]  upd_ras_ptr;

  int errors = 0;
  int checks = 0;

  gshare_branch_predictor dut (
    .clk           (clk),
    .resetn        (resetn),
    .fetch_valid   (fetch_valid),
    .pc            (pc),
    .pred_next_pc  (pred_next_pc),
    .pred_br_taken (pred_br_taken),
    .pred_ghr      (pred_ghr),
    .pred_ras_ptr  (pred_ras_ptr),
    .upd_en        (upd_en),
    .upd_inst_addr (upd_inst_addr),
    .upd_br_inst   (upd_br_inst),
    .upd_br_type   (upd_br_type),
    .upd_br_taken  (upd_br_taken),
    .upd_br_target (upd_br_target),
    .upd_mispredict(upd_mispredict),
    .upd_ghr       (upd_ghr),
    .upd_ras_ptr   (upd_ras_ptr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_upd();
    upd_en         = 1'b0;
    upd_inst_addr  = '0;
    upd_br_inst    = 1'b0;
    upd_br_type    = 2'b00;
    upd_br_taken   = 1'b0;
    upd_br_target  = '0;
    upd_mispredict = 1'b0;
    upd_ghr        = '0;
    upd_ras_ptr    = '0;
  endtask

  task automatic set_upd(input logic [31:0] addr, input logic [1:0] typ, input logic taken,
                         input logic [31:0] tgt, input logic mis, input logic [7:0] ghr,
                         input logic [2:0] rptr);
    upd_en         = 1'b1;
    upd_inst_addr  = addr;
    upd_br_inst    = 1'b1;
    upd_br_type    = typ;
    upd_br_taken   = taken;
    upd_br_target  = tgt;
    upd_mispredict = mis;
    upd_ghr        = ghr;
    upd_ras_ptr    = rptr;
  endtask

  // One update-only cycle with no fetch.
  task automatic train(input logic [31:0] addr, input logic [1:0] typ, input logic taken,
                       input logic [31:0] tgt, input logic [7:0] ghr);
    fetch_valid = 1'b0;
    set_upd(addr, typ, taken, tgt, 1'b0, ghr, 3'd0);
    tick();
    clear_upd();
  endtask

  task automatic fetch(input logic [31:0] a);
    pc          = a;
    fetch_valid = 1'b1;
    tick();
    fetch_valid = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    fetch_valid = 1'b0;
    pc = 32'h1C00_0000;
    clear_upd();
    #1;
    checks++;
    if (pred_next_pc !== 32'h1C00_0004) begin
      errors++; $display("FAIL reset_in_next_pc: got %h want 1c000004", pred_next_pc);
    end
    tick(); tick();
    @(negedge clk);
    resetn = 1'b1;
    #1;
    checks++;
    if (pred_br_taken !== 1'b0) begin
      errors++; $display("FAIL reset_taken: got %b want 0", pred_br_taken);
    end
    checks++;
    if (pred_next_pc !== 32'h1C00_0004) begin
      errors++; $display("FAIL reset_next_pc: got %h want 1c000004", pred_next_pc);
    end
    checks++;
    if (pred_ghr !== 8'h00 || pred_ras_ptr !== 3'd0) begin
      errors++; $display("FAIL reset_ghr_ptr: got %h/%0d want 00/0", pred_ghr, pred_ras_ptr);
    end
  endtask

  task automatic test_cond_train();
    train(32'h1C00_0010, 2'b00, 1'b1, 32'h1C00_0100, 8'h00);
    train(32'h1C00_0010, 2'b00, 1'b1, 32'h1C00_0100, 8'h00);
    pc = 32'h1C00_0010;
    #1;
    checks++;
    if (pred_br_taken !== 1'b1 || pred_next_pc !== 32'h1C00_0100) begin
      errors++;
      $display("FAIL cond_taken: got %b %h want 1 1c000100", pred_br_taken, pred_next_pc);
    end
    // Same BTB index, different tag: must miss.
    pc = 32'h1D00_0010;
    #1;
    checks++;
    if (pred_br_taken !== 1'b0 || pred_next_pc !== 32'h1D00_0014) begin
      errors++;
      $display("FAIL tag_miss: got %b %h want 0 1d000014", pred_br_taken, pred_next_pc);
    end
    // Counter 11 saturates, then one not-taken leaves it weakly taken.
    train(32'h1C00_0010, 2'b00, 1'b1, 32'h1C00_0100, 8'h00);
    train(32'h1C00_0010, 2'b00, 1'b0, 32'h1C00_0100, 8'h00);
    pc = 32'h1C00_0010;
    #1;
    checks++;
    if (pred_br_taken !== 1'b1) begin
      errors++; $display("FAIL cond_saturate: got %b want 1", pred_br_taken);
    end
    train(32'h1C00_0010, 2'b00, 1'b0, 32'h1C00_0100, 8'h00);
    pc = 32'h1C00_0010;
    #1;
    checks++;
    if (pred_br_taken !== 1'b0 || pred_next_pc !== 32'h1C00_0014) begin
      errors++;
      $display("FAIL cond_weak_nt: got %b %h want 0 1c000014", pred_br_taken, pred_next_pc);
    end
    train(32'h1C00_0010, 2'b00, 1'b1, 32'h1C00_0100, 8'h00);
    fetch(32'h1C00_0010);
    checks++;
    if (pred_ghr !== 8'h01) begin
      errors++; $display("FAIL cond_ghr_shift: got %h want 01", pred_ghr);
    end
    // With ghr=1 the PHT index moves to an untrained counter.
    pc = 32'h1C00_0010;
    #1;
    checks++;
    if (pred_br_taken !== 1'b0 || pred_next_pc !== 32'h1C00_0014) begin
      errors++;
      $display("FAIL gshare_index: got %b %h want 0 1c000014", pred_br_taken, pred_next_pc);
    end
  endtask

  task automatic test_call_return();
    train(32'h1C00_0020, 2'b10, 1'b1, 32'h1C00_0200, 8'h00);
    train(32'h1C00_0204, 2'b11, 1'b1, 32'h0000_0000, 8'h00);
    pc = 32'h1C00_0020;
    #1;
    checks++;
    if (pred_br_taken !== 1'b1 || pred_next_pc !== 32'h1C00_0200 || pred_ras_ptr !== 3'd0) begin
      errors++;
      $display("FAIL call_lookup: got %b %h %0d want 1 1c000200 0",
               pred_br_taken, pred_next_pc, pred_ras_ptr);
    end
    fetch(32'h1C00_0020);
    checks++;
    if (pred_ras_ptr !== 3'd1) begin
      errors++; $display("FAIL call_push_ptr: got %0d want 1", pred_ras_ptr);
    end
    pc = 32'h1C00_0204;
    #1;
    checks++;
    if (pred_br_taken !== 1'b1 || pred_next_pc !== 32'h1C00_0024) begin
      errors++;
      $display("FAIL ret_lookup: got %b %h want 1 1c000024", pred_br_taken, pred_next_pc);
    end
    fetch(32'h1C00_0204);
    checks++;
    if (pred_ras_ptr !== 3'd0 || pred_ghr !== 8'h01) begin
      errors++; $display("FAIL ret_pop: got %0d/%h want 0/01", pred_ras_ptr, pred_ghr);
    end
  endtask

  task automatic test_ras_wrap();
    train(32'h1C00_0030, 2'b10, 1'b1, 32'h1C00_0200, 8'h00);
    for (int i = 0; i < 8; i++) fetch(32'h1C00_0020);
    checks++;
    if (pred_ras_ptr !== 3'd0) begin
      errors++; $display("FAIL ras_wrap8: got %0d want 0", pred_ras_ptr);
    end
    fetch(32'h1C00_0030);
    checks++;
    if (pred_ras_ptr !== 3'd1) begin
      errors++; $display("FAIL ras_wrap9: got %0d want 1", pred_ras_ptr);
    end
    pc = 32'h1C00_0204;
    #1;
    checks++;
    if (pred_next_pc !== 32'h1C00_0034) begin
      errors++; $display("FAIL ras_wrap_top: got %h want 1c000034", pred_next_pc);
    end
    fetch(32'h1C00_0204);
    checks++;
    if (pred_ras_ptr !== 3'd0) begin
      errors++; $display("FAIL ras_wrap_pop: got %0d want 0", pred_ras_ptr);
    end
  endtask

  task automatic test_recovery();
    // Cond not-taken mispredict alongside a fetched call that must be squashed.
    set_upd(32'h1C00_0040, 2'b00, 1'b0, 32'h1C00_0400, 1'b1, 8'hA5, 3'd3);
    pc = 32'h1C00_0020;
    fetch_valid = 1'b1;
    #1;
    checks++;
    if (pred_next_pc !== 32'h1C00_0200) begin
      errors++; $display("FAIL rec_same_cycle_lookup: got %h want 1c000200", pred_next_pc);
    end
    tick();
    fetch_valid = 1'b0;
    clear_upd();
    checks++;
    if (pred_ghr !== 8'h4A || pred_ras_ptr !== 3'd3) begin
      errors++; $display("FAIL rec_cond: got %h/%0d want 4a/3", pred_ghr, pred_ras_ptr);
    end
    pc = 32'h1C00_0204;
    #1;
    checks++;
    if (pred_next_pc !== 32'h1C00_0024) begin
      errors++; $display("FAIL rec_ras3: got %h want 1c000024", pred_next_pc);
    end
    // Jump mispredict: ghr restored unshifted, tos restored to 1.
    set_upd(32'h1C00_0060, 2'b01, 1'b1, 32'h1C00_0300, 1'b1, 8'h12, 3'd1);
    tick();
    clear_upd();
    pc = 32'h1C00_0204;
    #1;
    checks++;
    if (pred_ghr !== 8'h12 || pred_ras_ptr !== 3'd1 || pred_next_pc !== 32'h1C00_0034) begin
      errors++;
      $display("FAIL rec_jump: got %h/%0d/%h want 12/1/1c000034",
               pred_ghr, pred_ras_ptr, pred_next_pc);
    end
    pc = 32'h1C00_0060;
    #1;
    checks++;
    if (pred_br_taken !== 1'b1 || pred_next_pc !== 32'h1C00_0300) begin
      errors++;
      $display("FAIL jump_trained: got %b %h want 1 1c000300", pred_br_taken, pred_next_pc);
    end
    // Call mispredict pushes its own return address.
    set_upd(32'h1C00_0050, 2'b10, 1'b1, 32'h1C00_0500, 1'b1, 8'h33, 3'd5);
    tick();
    clear_upd();
    pc = 32'h1C00_0204;
    #1;
    checks++;
    if (pred_ghr !== 8'h33 || pred_ras_ptr !== 3'd6 || pred_next_pc !== 32'h1C00_0054) begin
      errors++;
      $display("FAIL rec_call: got %h/%0d/%h want 33/6/1c000054",
               pred_ghr, pred_ras_ptr, pred_next_pc);
    end
    // Return mispredict from ptr 0 wraps to 7.
    set_upd(32'h1C00_0204, 2'b11, 1'b1, 32'h0000_0000, 1'b1, 8'h0F, 3'd0);
    tick();
    clear_upd();
    checks++;
    if (pred_ghr !== 8'h0F || pred_ras_ptr !== 3'd7) begin
      errors++; $display("FAIL rec_ret: got %h/%0d want 0f/7", pred_ghr, pred_ras_ptr);
    end
  endtask

  task automatic test_async_reset();
    pc = 32'h1C00_0020;
    @(negedge clk);
    #1;
    resetn = 1'b0;
    #1;
    checks++;
    if (pred_br_taken !== 1'b0 || pred_next_pc !== 32'h1C00_0024) begin
      errors++;
      $display("FAIL async_rst_pred: got %b %h want 0 1c000024", pred_br_taken, pred_next_pc);
    end
    checks++;
    if (pred_ghr !== 8'h00 || pred_ras_ptr !== 3'd0) begin
      errors++; $display("FAIL async_rst_state: got %h/%0d want 00/0", pred_ghr, pred_ras_ptr);
    end
    tick();
    @(negedge clk);
    resetn = 1'b1;
    pc = 32'h1C00_0010;
    #1;
    checks++;
    if (pred_br_taken !== 1'b0 || pred_next_pc !== 32'h1C00_0014) begin
      errors++;
      $display("FAIL post_rst_miss: got %b %h want 0 1c000014", pred_br_taken, pred_next_pc);
    end
    pc = 32'hFFFF_FFFC;
    #1;
    checks++;
    if (pred_next_pc !== 32'h0000_0000) begin
      errors++; $display("FAIL pc_wrap: got %h want 00000000", pred_next_pc);
    end
  endtask

  initial begin
    test_reset();
    test_cond_train();
    test_call_return();
    test_ras_wrap();
    test_recovery();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
